// File: rtl/binary_2_7seg_pkg.sv
// Shared types, seven-segment glyph constants and the binary-to-BCD helper.
package binary_2_7seg_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t hun;
        bcd_t ten;
        bcd_t one;
    } bcd3_t;

    // Active-low glyphs, bit6..bit0 = g..a
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Any digit code above 9 routes the decoder to its blank pattern.
    localparam bcd_t DIGIT_BLANK = 4'hF;

    // Double dabble over an 8-bit input; hundreds never exceeds 2.
    function automatic bcd3_t to_bcd(input logic [7:0] n);
        logic [19:0] s;
        s = {12'd0, n};
        for (int i = 0; i < 8; i++) begin
            if (s[11:8]  >= 4'd5) s[11:8]  = s[11:8]  + 4'd3;
            if (s[15:12] >= 4'd5) s[15:12] = s[15:12] + 4'd3;
            if (s[19:16] >= 4'd5) s[19:16] = s[19:16] + 4'd3;
            s = s << 1;
        end
        return '{hun: s[19:16], ten: s[15:12], one: s[11:8]};
    endfunction

endpackage

// File: rtl/binary_2_7seg_decoder.sv
// Combinational BCD digit to seven-segment decoder; codes 10..15 blank.
module seg7_decoder
    import binary_2_7seg_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  bcd_t       digit,
    output logic [6:0] seg
);

    logic [6:0] pat;

    always_comb begin
        pat = SEG_BLANK;
        case (digit)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
    end

    assign seg = SEG_ACTIVE_LOW ? pat : ~pat;

endmodule

// File: rtl/binary_2_7seg.sv
// 8-bit binary to three seven-segment digits, two-stage pipeline (BCD, then segments).
// Define BINARY_2_7SEG_LEADING_BLANK_EN to blank leading zeros on D2/D1.
module binary_2_7seg
    import binary_2_7seg_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] N,
    output logic [6:0] D0,
    output logic [6:0] D1,
    output logic [6:0] D2
);

    localparam int         NUM_DIG   = 3;
    localparam logic [6:0] BLANK_OUT = SEG_ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

    bcd3_t                          bcd_q;
    bcd_t [NUM_DIG-1:0]             dig;
    logic [NUM_DIG-1:0][6:0]        seg_d;
    logic [NUM_DIG-1:0][6:0]        seg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bcd_q <= '0;
        else     bcd_q <= to_bcd(N);
    end

    // Leading-zero blanking rides on the decoder's out-of-range blank.
    always_comb begin
        dig[0] = bcd_q.one;
        dig[1] = bcd_q.ten;
        dig[2] = bcd_q.hun;
`ifdef BINARY_2_7SEG_LEADING_BLANK_EN
        if (bcd_q.hun == 4'd0) begin
            dig[2] = DIGIT_BLANK;
            if (bcd_q.ten == 4'd0) dig[1] = DIGIT_BLANK;
        end
`endif
    end

    for (genvar g = 0; g < NUM_DIG; g++) begin : g_dec
        seg7_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec (
            .digit (dig[g]),
            .seg   (seg_d[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) seg_q <= {NUM_DIG{BLANK_OUT}};
        else     seg_q <= seg_d;
    end

    assign D0 = seg_q[0];
    assign D1 = seg_q[1];
    assign D2 = seg_q[2];

endmodule

// File: tb/tb_binary_2_7seg.sv
// Randomized self-checking bench for binary_2_7seg (both segment polarities).
module tb_binary_2_7seg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] N   = 8'd0;
    logic [6:0] D0, D1, D2;
    logic [6:0] H0, H1, H2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    binary_2_7seg #(.SEG_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .N(N), .D0(D0), .D1(D1), .D2(D2)
    );

    binary_2_7seg #(.SEG_ACTIVE_LOW(0)) dut_ah (
        .clk(clk), .rst(rst), .N(N), .D0(H0), .D1(H1), .D2(H2)
    );

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected {D2,D1,D0} for value n from decimal arithmetic.
    function automatic logic [20:0] model(input int n, input bit al);
        int h = n / 100;
        int t = (n / 10) % 10;
        int o = n % 10;
        logic [6:0] b2, b1, b0;
        b2 = glyph(h);
        b1 = glyph(t);
        b0 = glyph(o);
`ifdef BINARY_2_7SEG_LEADING_BLANK_EN
        if (h == 0) b2 = 7'b1111111;
        if (h == 0 && t == 0) b1 = 7'b1111111;
`endif
        return al ? {b2, b1, b0} : ~{b2, b1, b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        N   = 8'd200;
        repeat (3) tick();
        checks++;
        if ({D2, D1, D0} !== {3{7'b1111111}}) begin
            errors++;
            $display("FAIL reset_low: got %b required %b", {D2, D1, D0}, {3{7'b1111111}});
        end
        checks++;
        if ({H2, H1, H0} !== 21'd0) begin
            errors++;
            $display("FAIL reset_high: got %b required %b", {H2, H1, H0}, 21'd0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_known();
        logic [20:0] req;
        N = 8'd255;
        repeat (2) tick();
        req = {7'b0100100, 7'b0010010, 7'b0010010};
        checks++;
        if ({D2, D1, D0} !== req) begin
            errors++;
            $display("FAIL n255: got %b required %b", {D2, D1, D0}, req);
        end
`ifdef BINARY_2_7SEG_LEADING_BLANK_EN
        N = 8'd7;
        repeat (2) tick();
        req = {7'b1111111, 7'b1111111, 7'b1111000};
        checks++;
        if ({D2, D1, D0} !== req) begin
            errors++;
            $display("FAIL n7_blank: got %b required %b", {D2, D1, D0}, req);
        end
        N = 8'd105;
        repeat (2) tick();
        req = {7'b1111001, 7'b1000000, 7'b0010010};
        checks++;
        if ({D2, D1, D0} !== req) begin
            errors++;
            $display("FAIL n105_blank: got %b required %b", {D2, D1, D0}, req);
        end
`else
        N = 8'd0;
        repeat (2) tick();
        req = {3{7'b1000000}};
        checks++;
        if ({D2, D1, D0} !== req) begin
            errors++;
            $display("FAIL n0_zeros: got %b required %b", {D2, D1, D0}, req);
        end
        N = 8'd8;
        repeat (2) tick();
        req = {7'b0111111, 7'b0111111, 7'b1111111};
        checks++;
        if ({H2, H1, H0} !== req) begin
            errors++;
            $display("FAIL n8_active_high: got %b required %b", {H2, H1, H0}, req);
        end
`endif
    endtask

    // Output after edge i must reflect the value presented before edge i-1.
    task automatic test_back_to_back();
        int vals[8] = '{0, 0, 9, 10, 99, 100, 100, 100};
        for (int i = 0; i < 8; i++) begin
            N = vals[i][7:0];
            tick();
            if (i >= 1) begin
                checks++;
                if ({D2, D1, D0} !== model(vals[i-1], 1'b1)) begin
                    errors++;
                    $display("FAIL b2b[%0d] n=%0d: got %b required %b", i, vals[i-1],
                             {D2, D1, D0}, model(vals[i-1], 1'b1));
                end
            end
        end
    endtask

    task automatic test_random();
        int prev;
        int n;
        prev = int'(N);
        tick();
        for (int i = 0; i < 300; i++) begin
            n = int'($urandom_range(0, 255));
            N = n[7:0];
            tick();
            checks++;
            if ({D2, D1, D0} !== model(prev, 1'b1)) begin
                errors++;
                $display("FAIL rand_low n=%0d: got %b required %b", prev, {D2, D1, D0},
                         model(prev, 1'b1));
            end
            checks++;
            if ({H2, H1, H0} !== model(prev, 1'b0)) begin
                errors++;
                $display("FAIL rand_high n=%0d: got %b required %b", prev, {H2, H1, H0},
                         model(prev, 1'b0));
            end
            prev = n;
        end
    endtask

    task automatic test_reset_mid();
        N = 8'd77;
        tick();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({D2, D1, D0} !== {3{7'b1111111}} || {H2, H1, H0} !== 21'd0) begin
            errors++;
            $display("FAIL rst_async: got %b / %b required all blank", {D2, D1, D0}, {H2, H1, H0});
        end
        repeat (3) tick();
        checks++;
        if ({D2, D1, D0} !== {3{7'b1111111}}) begin
            errors++;
            $display("FAIL rst_hold: got %b required %b", {D2, D1, D0}, {3{7'b1111111}});
        end
        @(negedge clk);
        rst = 1'b0;
        N   = 8'd123;
        tick();
        // In-flight 77 is gone: the first edge shows the cleared (zero) digits.
        checks++;
        if ({D2, D1, D0} !== model(0, 1'b1)) begin
            errors++;
            $display("FAIL rst_edge1: got %b required %b", {D2, D1, D0}, model(0, 1'b1));
        end
        tick();
        checks++;
        if ({D2, D1, D0} !== model(123, 1'b1)) begin
            errors++;
            $display("FAIL rst_edge2: got %b required %b", {D2, D1, D0}, model(123, 1'b1));
        end
        checks++;
        if ({H2, H1, H0} !== model(123, 1'b0)) begin
            errors++;
            $display("FAIL rst_edge2_high: got %b required %b", {H2, H1, H0}, model(123, 1'b0));
        end
    endtask

    initial begin
        test_reset();
        test_known();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
